mdu_req_queue: RTL and testbench
================================

MDU_REQ_QUEUE -- requirements
Module: mdu_req_queue

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with ports clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-002 in_valid  input  1  E-stage MDU request present this cycle.
REQ-003 in_op  input  4  request op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
REQ-004 in_a  input  32  operand A, or the write data for mthi/mtlo.
REQ-005 in_b  input  32  operand B.
REQ-006 in_ready  output  1  queue can accept a request this cycle.
REQ-007 busy  input  1  MDU busy flag.
REQ-008 start  output  1  one-cycle issue pulse to the MDU.
REQ-009 MDU_opA  output  32  issued operand A.
REQ-010 MDU_opB  output  32  issued operand B.
REQ-011 MDUop  output  4  issued op code; 0 whenever start=0.
REQ-012 pending  output  1  any MDU work outstanding; the pipeline stalls mfhi/mflo on it.

Function
REQ-013 The queue SHALL be a 4-entry FIFO of {op, a, b}, with 3-bit read/write pointers (2 index bits plus 1 wrap bit) and full/empty derived from the pointers.
REQ-014 A push SHALL occur at a clock edge iff in_valid=1, in_op in 1..6, and in_ready=1.
REQ-015 Requests with in_op=0 or in_op>6 SHALL be dropped silently, with no pointer change.
REQ-016 in_ready SHALL equal !full; when the queue is full, a push is refused even if a pop occurs in the same cycle.
REQ-017 The issue condition SHALL be: queue not empty, busy=0, and start=0.
- start=0 is required because MDU busy rises only one cycle after start.
REQ-018 On an issue edge, the block SHALL register start=1, MDUop=head.op, MDU_opA=head.a and MDU_opB=head.b, and pop the head.
REQ-019 In a non-issue cycle, start and MDUop SHALL register 0, and MDU_opA/MDU_opB SHALL hold their values.
REQ-020 A push and a pop in the same cycle (queue not full) SHALL both take effect, leaving the count unchanged.
REQ-021 Minimum latency SHALL be a push at edge N producing start=1 during cycle N+1 to N+2, i.e. one idle cycle with the entry visible, then the registered pulse; there is no bypass path.
REQ-022 start SHALL never be high on two consecutive cycles.
REQ-023 Ops 5 and 6 SHALL follow the same issue rules as 1..4, with no special fast path.
REQ-024 Order SHALL be strictly FIFO, with no reordering across ops.
REQ-025 pending SHALL be combinational: (count != 0) | start | busy.
REQ-026 Pointer wrap-around SHALL be modulo 4 on the index bits; the wrap bit toggles on index overflow.

Reset
REQ-027 When reset=1 at an edge, the block SHALL clear:
- pointers and count to 0;
- start=0, MDUop=0, MDU_opA=0, MDU_opB=0.
REQ-028 Reset SHALL take priority over a simultaneous push or issue; queued entries are discarded.
REQ-029 Reset asserted mid-operation SHALL leave no residual start pulse after the reset edge.
REQ-030 After reset the block SHALL present in_ready=1, and pending SHALL equal the busy input.

Verification
REQ-031 The bench SHALL cover single mult:
- stimulus: push op 1, A=-17 (0xFFFFFFEF), B=101 at edge N, busy=0;
- response: start=1, MDUop=1, MDU_opA=0xFFFFFFEF, MDU_opB=101 in cycle N+2 only; pending=1 from cycle N+1.
REQ-032 The bench SHALL cover back-to-back ops:
- stimulus: push op 3 (101, -10) then op 4 (-101, 10) on consecutive edges; the MDU model holds busy for 10 cycles after the first start;
- response: the second start appears only in the cycle after the edge where busy=0 is first sampled, with MDUop=4.
REQ-033 The bench SHALL cover fill/full:
- stimulus: hold busy=1 and push 5 valid requests;
- response: in_ready=0 after the 4th, the 5th is dropped, and releasing busy issues exactly 4 starts in order 1,2,3,4 with at least one gap cycle between starts.
REQ-034 The bench SHALL cover invalid op:
- stimulus: push in_op=0, then in_op=7;
- response: no pointer change, no start, pending=0 with busy=0.
REQ-035 The bench SHALL cover mthi/mtlo:
- stimulus: push op 5, A=123, then op 6, A=4433;
- response: two starts carrying MDUop 5/123 then 6/4433, in order.
REQ-036 The bench SHALL cover reset mid-operation:
- stimulus: with 3 entries queued and start=1, assert reset for one edge;
- response: the next cycle shows start=0, MDUop=0, in_ready=1, pending=busy, and no later start without a new push.

Source files
------------

// File: rtl/mdu_req_queue_if.sv
// rtl/mdu_req_queue_if.sv - request, issue and status signals of the MDU request queue
interface mdu_req_queue_if;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ready;
    logic        busy;
    logic        start;
    logic [31:0] MDU_opA;
    logic [31:0] MDU_opB;
    logic [3:0]  MDUop;
    logic        pending;

    modport master (
        output in_valid, in_op, in_a, in_b, busy,
        input  in_ready, start, MDU_opA, MDU_opB, MDUop, pending
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, busy,
        output in_ready, start, MDU_opA, MDU_opB, MDUop, pending
    );
endinterface

// File: rtl/mdu_req_queue.sv
// rtl/mdu_req_queue.sv - 4-entry FIFO buffering E-stage MDU requests and issuing them as start pulses
module mdu_req_queue (
    input  logic           clk,
    input  logic           reset,
    mdu_req_queue_if.slave mdu
);
    logic [3:0]  op_mem [4];
    logic [31:0] a_mem  [4];
    logic [31:0] b_mem  [4];

    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        op_ok;
    logic        push;
    logic        issue;

    logic        start_q;
    logic [3:0]  op_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;

    // Occupancy is derived from the pointers, so clearing them clears the count.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[1:0] == rd_ptr[1:0]) && (wr_ptr[2] != rd_ptr[2]);
    assign op_ok = (mdu.in_op >= 4'd1) && (mdu.in_op <= 4'd6);
    assign push  = mdu.in_valid && op_ok && !full;
    // busy only rises the cycle after start, so a live start also blocks issue.
    assign issue = !empty && !mdu.busy && !start_q;

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr[1:0]] <= mdu.in_op;
            a_mem[wr_ptr[1:0]]  <= mdu.in_a;
            b_mem[wr_ptr[1:0]]  <= mdu.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= 3'd0;
            rd_ptr  <= 3'd0;
            start_q <= 1'b0;
            op_q    <= 4'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (issue) begin
                rd_ptr  <= rd_ptr + 3'd1;
                start_q <= 1'b1;
                op_q    <= op_mem[rd_ptr[1:0]];
                opa_q   <= a_mem[rd_ptr[1:0]];
                opb_q   <= b_mem[rd_ptr[1:0]];
            end else begin
                start_q <= 1'b0;
                op_q    <= 4'd0;
            end
        end
    end

    assign mdu.in_ready = !full;
    assign mdu.start    = start_q;
    assign mdu.MDUop    = op_q;
    assign mdu.MDU_opA  = opa_q;
    assign mdu.MDU_opB  = opb_q;
    assign mdu.pending  = (count != 3'd0) | start_q | mdu.busy;
endmodule

// File: tb/tb_mdu_req_queue.sv
// tb/tb_mdu_req_queue.sv - scoreboard bench for mdu_req_queue
module tb_mdu_req_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_req_queue_if mdu ();
    mdu_req_queue dut (.clk(clk), .reset(reset), .mdu(mdu));

    int checks = 0;
    int failures = 0;
    int start_count = 0;
    logic [67:0] sb [$];
    logic [67:0] mon_exp;
    logic        prev_start = 1'b0;

    // MDU model: busy for busy_len cycles starting the cycle after start, or forced by busy_hold.
    logic busy_hold = 1'b0;
    int   busy_len = 0;
    int   busy_cnt = 0;
    assign mdu.busy = busy_hold | (busy_cnt != 0);

    always @(posedge clk) begin
        if (reset) busy_cnt <= 0;
        else if (mdu.start === 1'b1) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (mdu.start === 1'b1) begin
            start_count++;
            checks++;
            if (prev_start) begin
                failures++;
                $display("FAIL start_consecutive actual=1 required=0");
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_start actual_op=%0d required=no_start", mdu.MDUop);
            end else begin
                mon_exp = sb.pop_front();
                if ({mdu.MDUop, mdu.MDU_opA, mdu.MDU_opB} !== mon_exp) begin
                    failures++;
                    $display("FAIL issue_data actual=%h/%h/%h required=%h/%h/%h",
                             mdu.MDUop, mdu.MDU_opA, mdu.MDU_opB,
                             mon_exp[67:64], mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
        prev_start = (mdu.start === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit accept);
        mdu.in_valid = 1'b1;
        mdu.in_op    = op;
        mdu.in_a     = a;
        mdu.in_b     = b;
        if (accept) sb.push_back({op, a, b});
        tick();
        mdu.in_valid = 1'b0;
        mdu.in_op    = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (mdu.start !== 1'b0) begin failures++; $display("FAIL reset_start actual=%b required=0", mdu.start); end
        checks++; if (mdu.MDUop !== 4'd0) begin failures++; $display("FAIL reset_mduop actual=%0d required=0", mdu.MDUop); end
        checks++; if (mdu.MDU_opA !== 32'd0) begin failures++; $display("FAIL reset_opa actual=%h required=0", mdu.MDU_opA); end
        checks++; if (mdu.MDU_opB !== 32'd0) begin failures++; $display("FAIL reset_opb actual=%h required=0", mdu.MDU_opB); end
        reset = 1'b0;
        tick();
        checks++; if (mdu.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", mdu.in_ready); end
        checks++; if (mdu.pending !== 1'b0) begin failures++; $display("FAIL reset_pending_idle actual=%b required=0", mdu.pending); end
        busy_hold = 1'b1;
        #1;
        checks++; if (mdu.pending !== 1'b1) begin failures++; $display("FAIL reset_pending_busy actual=%b required=1", mdu.pending); end
        busy_hold = 1'b0;
        tick();
    endtask

    task automatic test_single_mult();
        push_req(4'd1, 32'hFFFF_FFEF, 32'd101, 1'b1);
        checks++; if (mdu.start !== 1'b0) begin failures++; $display("FAIL mult_no_bypass actual=%b required=0", mdu.start); end
        checks++; if (mdu.pending !== 1'b1) begin failures++; $display("FAIL mult_pending_early actual=%b required=1", mdu.pending); end
        tick();
        checks++; if (mdu.start !== 1'b1) begin failures++; $display("FAIL mult_start actual=%b required=1", mdu.start); end
        checks++; if (mdu.MDUop !== 4'd1) begin failures++; $display("FAIL mult_op actual=%0d required=1", mdu.MDUop); end
        checks++; if (mdu.MDU_opA !== 32'hFFFF_FFEF) begin failures++; $display("FAIL mult_opa actual=%h required=ffffffef", mdu.MDU_opA); end
        checks++; if (mdu.MDU_opB !== 32'd101) begin failures++; $display("FAIL mult_opb actual=%h required=00000065", mdu.MDU_opB); end
        tick();
        checks++; if (mdu.start !== 1'b0) begin failures++; $display("FAIL mult_start_pulse actual=%b required=0", mdu.start); end
        checks++; if (mdu.MDUop !== 4'd0) begin failures++; $display("FAIL mult_op_clear actual=%0d required=0", mdu.MDUop); end
        checks++; if (mdu.MDU_opA !== 32'hFFFF_FFEF) begin failures++; $display("FAIL mult_opa_hold actual=%h required=ffffffef", mdu.MDU_opA); end
        repeat (3) tick();
        checks++; if (mdu.pending !== 1'b0) begin failures++; $display("FAIL mult_pending_done actual=%b required=0", mdu.pending); end
    endtask

    task automatic test_back_to_back();
        int found;
        logic b1;
        logic b2;
        busy_len = 10;
        push_req(4'd3, 32'd101, -32'sd10, 1'b1);
        push_req(4'd4, -32'sd101, 32'd10, 1'b1);
        checks++; if (mdu.start !== 1'b1 || mdu.MDUop !== 4'd3) begin failures++; $display("FAIL b2b_first actual=%b/%0d required=1/3", mdu.start, mdu.MDUop); end
        found = -1;
        b1 = mdu.busy;
        b2 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (mdu.start === 1'b1) begin
                found = k;
                break;
            end
            b2 = b1;
            b1 = mdu.busy;
        end
        checks++; if (found != 12) begin failures++; $display("FAIL b2b_gap actual=%0d required=12", found); end
        checks++; if (b1 !== 1'b0 || b2 !== 1'b1) begin failures++; $display("FAIL b2b_busy_edge actual=%b%b required=10", b2, b1); end
        checks++; if (mdu.MDUop !== 4'd4) begin failures++; $display("FAIL b2b_second_op actual=%0d required=4", mdu.MDUop); end
        busy_len = 0;
        repeat (15) tick();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain actual=%0d required=0", sb.size()); end
    endtask

    task automatic test_fill_full();
        int s0;
        busy_hold = 1'b1;
        tick();
        s0 = start_count;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mdu.in_ready !== (i < 4)) begin
                failures++;
                $display("FAIL fill_in_ready_%0d actual=%b required=%b", i, mdu.in_ready, (i < 4));
            end
            push_req(4'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i), (i < 4));
        end
        checks++; if (mdu.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready actual=%b required=0", mdu.in_ready); end
        checks++; if (start_count != s0) begin failures++; $display("FAIL full_no_start actual=%0d required=0", start_count - s0); end
        // Refused push on the same edge as the first pop.
        busy_hold = 1'b0;
        push_req(4'd6, 32'hDEAD, 32'd0, 1'b0);
        checks++; if (mdu.start !== 1'b1) begin failures++; $display("FAIL full_release_start actual=%b required=1", mdu.start); end
        repeat (20) tick();
        checks++; if (start_count - s0 != 4) begin failures++; $display("FAIL full_start_count actual=%0d required=4", start_count - s0); end
        checks++; if (mdu.pending !== 1'b0) begin failures++; $display("FAIL full_pending_done actual=%b required=0", mdu.pending); end
    endtask

    task automatic test_invalid_op();
        int s0;
        s0 = start_count;
        push_req(4'd0, 32'd1, 32'd2, 1'b0);
        push_req(4'd7, 32'd3, 32'd4, 1'b0);
        push_req(4'd15, 32'd5, 32'd6, 1'b0);
        checks++; if (mdu.pending !== 1'b0) begin failures++; $display("FAIL invalid_pending actual=%b required=0", mdu.pending); end
        repeat (5) tick();
        checks++; if (start_count != s0) begin failures++; $display("FAIL invalid_start actual=%0d required=0", start_count - s0); end
        checks++; if (mdu.in_ready !== 1'b1) begin failures++; $display("FAIL invalid_in_ready actual=%b required=1", mdu.in_ready); end
        push_req(4'd2, 32'h55, 32'hAA, 1'b1);
        repeat (4) tick();
        checks++; if (start_count - s0 != 1) begin failures++; $display("FAIL invalid_then_valid actual=%0d required=1", start_count - s0); end
    endtask

    task automatic test_mthi_mtlo();
        int s0;
        s0 = start_count;
        push_req(4'd5, 32'd123, 32'd0, 1'b1);
        push_req(4'd6, 32'd4433, 32'd0, 1'b1);
        repeat (10) tick();
        checks++; if (start_count - s0 != 2) begin failures++; $display("FAIL mt_start_count actual=%0d required=2", start_count - s0); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL mt_drain actual=%0d required=0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int s0;
        busy_hold = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push_req(4'(i + 1), 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b1);
        busy_hold = 1'b0;
        tick();
        checks++; if (mdu.start !== 1'b1) begin failures++; $display("FAIL mid_start_before actual=%b required=1", mdu.start); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        s0 = start_count;
        checks++; if (mdu.start !== 1'b0) begin failures++; $display("FAIL mid_start actual=%b required=0", mdu.start); end
        checks++; if (mdu.MDUop !== 4'd0) begin failures++; $display("FAIL mid_op actual=%0d required=0", mdu.MDUop); end
        checks++; if (mdu.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready actual=%b required=1", mdu.in_ready); end
        checks++; if (mdu.pending !== mdu.busy) begin failures++; $display("FAIL mid_pending actual=%b required=%b", mdu.pending, mdu.busy); end
        repeat (10) tick();
        checks++; if (start_count != s0) begin failures++; $display("FAIL mid_no_restart actual=%0d required=0", start_count - s0); end
        checks++; if (mdu.pending !== 1'b0) begin failures++; $display("FAIL mid_pending_idle actual=%b required=0", mdu.pending); end
    endtask

    initial begin
        mdu.in_valid = 1'b0;
        mdu.in_op    = 4'd0;
        mdu.in_a     = 32'd0;
        mdu.in_b     = 32'd0;
        test_reset();
        test_single_mult();
        test_back_to_back();
        test_fill_full();
        test_invalid_op();
        test_mthi_mtlo();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
